// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared state encoding and G1/G2 enable decode for the decoder family.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // G1 is active-high, G2 active-low; any other combination disables.
    function automatic logic g_enable(input logic [1:0] ena);
        return ena[1] & ~ena[0];
    endfunction

endpackage

// File: rtl/scan_decoder_onehot.sv
// onehot_n_decoder: combinational SEL_W-to-2**SEL_W active-low one-hot decode.
module onehot_n_decoder #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   data
);

    localparam int OUT_N = 2**SEL_W;

    assign data = ~(OUT_N'(1) << sel);

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered active-low decoder with G1/G2 enables and an auto-scan mode
// that sweeps every line with a programmable dwell time.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 16
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic [1:0]           iEna,
    input  logic                 iMode,
    input  logic [SEL_W-1:0]     iData,
    input  logic [DWELL_W-1:0]   iDwell,
    output logic [2**SEL_W-1:0]  oData,
    output logic [SEL_W-1:0]     oSel,
    output logic                 oWrap
);

    localparam int OUT_N = 2**SEL_W;

    state_t             state;
    state_t             next;
    logic [DWELL_W-1:0] cnt;
    logic               resume;
    logic [OUT_N-1:0]   lines;

    always_comb next = !g_enable(iEna) ? OFF : iMode ? SCAN : DIRECT;

    // resume marks a scan frozen by a disable; DIRECT or reset forces a fresh start at line 0.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state  <= OFF;
            oSel   <= '0;
            cnt    <= '0;
            oWrap  <= 1'b0;
            resume <= 1'b0;
        end else begin
            state <= next;
            oWrap <= 1'b0;
            if (next == DIRECT) begin
                oSel   <= iData;
                cnt    <= '0;
                resume <= 1'b0;
            end else if (next == SCAN) begin
                resume <= 1'b1;
                if (!resume) begin
                    oSel <= '0;
                    cnt  <= '0;
                end else if (cnt >= iDwell) begin
                    cnt   <= '0;
                    oSel  <= oSel + 1'b1;
                    oWrap <= &oSel;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    onehot_n_decoder #(.SEL_W(SEL_W)) u_dec (
        .sel  (oSel),
        .data (lines)
    );

    assign oData = (state == OFF) ? '1 : lines;

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed and random stimulus against a behavioural model, SEL_W=3 and SEL_W=4 side by side.
module tb_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ena;
    logic        mode;
    logic [2:0]  data;
    logic [3:0]  data4;
    logic [15:0] dwell;
    logic [7:0]  d3;
    logic [2:0]  s3;
    logic        w3;
    logic [15:0] d4;
    logic [3:0]  s4;
    logic        w4;

    int tests  = 0;
    int errors = 0;

    int m_sel3, m_sel4, m_cnt;
    bit m_on, m_res, m_w3, m_w4;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .DWELL_W(16)) dut3 (
        .iClk(clk), .iRst_n(rst_n), .iEna(ena), .iMode(mode), .iData(data),
        .iDwell(dwell), .oData(d3), .oSel(s3), .oWrap(w3)
    );

    scan_decoder #(.SEL_W(4), .DWELL_W(16)) dut4 (
        .iClk(clk), .iRst_n(rst_n), .iEna(ena), .iMode(mode), .iData(data4),
        .iDwell(dwell), .oData(d4), .oSel(s4), .oWrap(w4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural reference: line positions as plain integers, wrap detected by modulo arithmetic.
    task automatic model();
        m_w3 = 0;
        m_w4 = 0;
        if (!rst_n) begin
            m_on = 0; m_res = 0; m_sel3 = 0; m_sel4 = 0; m_cnt = 0;
        end else if (ena != 2'b10) begin
            m_on = 0;
        end else if (!mode) begin
            m_on = 1; m_res = 0; m_cnt = 0;
            m_sel3 = int'(data);
            m_sel4 = int'(data4);
        end else begin
            m_on = 1;
            if (!m_res) begin
                m_res = 1; m_sel3 = 0; m_sel4 = 0; m_cnt = 0;
            end else if (m_cnt >= int'(dwell)) begin
                m_cnt  = 0;
                m_sel3 = (m_sel3 + 1) % 8;
                m_sel4 = (m_sel4 + 1) % 16;
                m_w3   = (m_sel3 == 0);
                m_w4   = (m_sel4 == 0);
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        #1;
        check("data3", 32'(d3), m_on ? (32'hFF & ~(32'd1 << m_sel3)) : 32'hFF);
        check("sel3",  32'(s3), 32'(m_sel3));
        check("wrap3", 32'(w3), 32'(m_w3));
        check("data4", 32'(d4), m_on ? (32'hFFFF & ~(32'd1 << m_sel4)) : 32'hFFFF);
        check("sel4",  32'(s4), 32'(m_sel4));
        check("wrap4", 32'(w4), 32'(m_w4));
        check("lows3", 32'($countones(~d3)), m_on ? 32'd1 : 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ena   = 2'($urandom);
            mode  = 1'($urandom);
            data  = 3'($urandom);
            data4 = 4'($urandom);
            dwell = 16'($urandom);
            tick();
        end
        rst_n = 1'b1;
        ena = 2'b10; mode = 1'b0; data = 3'd5; data4 = 4'd5; dwell = 16'd0;
        tick();
        check("direct5", 32'(d3), 32'hDF);
        ena = 2'b11;
        tick();
        check("g2_off", 32'(d3), 32'hFF);
        ena = 2'b00;
        tick();
        ena = 2'b10; mode = 1'b1; dwell = 16'd0;
        for (int i = 0; i < 34; i++) tick();
        mode = 1'b0;
        tick();
        mode = 1'b1; dwell = 16'd3;
        for (int i = 0; i < 40; i++) tick();
        n = 0;
        while (s3 != 3'd2 && n < 100) begin
            tick();
            n++;
        end
        check("reach_sel2", 32'(s3), 32'd2);
        tick();
        ena = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        check("frozen_sel", 32'(s3), 32'd2);
        ena = 2'b10;
        n = 0;
        while (s3 == 3'd2 && n < 20) begin
            tick();
            n++;
        end
        check("resume_len", 32'(n), 32'd3);
        mode = 1'b0;
        tick();
        mode = 1'b1; dwell = 16'd100;
        for (int i = 0; i < 51; i++) tick();
        dwell = 16'd10;
        tick();
        check("fast_adv", 32'(s3), 32'd1);
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            ena   = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b10;
            mode  = ($urandom_range(0, 9) != 0);
            data  = 3'($urandom);
            data4 = 4'($urandom);
            dwell = 16'($urandom_range(0, 5));
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
